// File: rtl/reflet_bus_bridge_if.sv
// reflet_bus_bridge_if -- the memory-side request/acknowledge bus of the
// Reflet CPU bus bridge. The bridge holds the master modport and the memory
// holds the slave modport.
interface reflet_bus_bridge_if #(
    parameter int wordsize = 16
);
    logic [wordsize-1:0] bus_addr;
    logic [wordsize-1:0] bus_wdata;
    logic                bus_we;
    logic                bus_req;
    logic                bus_ack;
    logic [wordsize-1:0] bus_rdata;
    logic                bus_error;

    modport master (
        output bus_addr,
        output bus_wdata,
        output bus_we,
        output bus_req,
        output bus_error,
        input  bus_ack,
        input  bus_rdata
    );

    modport slave (
        input  bus_addr,
        input  bus_wdata,
        input  bus_we,
        input  bus_req,
        input  bus_error,
        output bus_ack,
        output bus_rdata
    );
endinterface

// File: rtl/reflet_bus_bridge.sv
// reflet_bus_bridge -- turns the Reflet CPU's combinational memory port into
// single registered bus transactions. The CPU is stalled until the access it
// presents matches the last completed transaction (the tag), so a held access
// is issued exactly once.
// Optional feature: define REFLET_BUS_TIMEOUT_EN to abort a transaction after
// timeout_cycles REQ cycles without bus_ack (reads return all-ones and
// bus_error pulses). Without it, REQ waits for bus_ack indefinitely.
module reflet_bus_bridge #(
    parameter int wordsize       = 16,
    parameter int timeout_cycles = 255
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [wordsize-1:0] cpu_addr,
    input  logic [wordsize-1:0] cpu_data_out,
    input  logic                cpu_write_en,
    output logic [wordsize-1:0] cpu_data_in,
    output logic                stall,
    reflet_bus_bridge_if.master bus
);
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_REQ  = 1'b1;

    // Elaboration-time parameter sanity checks
    if (!(wordsize == 8 || wordsize == 16 || wordsize == 32 || wordsize == 64)) begin : g_bad_wordsize
        $error("reflet_bus_bridge: wordsize must be 8, 16, 32 or 64");
    end
    if (timeout_cycles < 1) begin : g_bad_timeout
        $error("reflet_bus_bridge: timeout_cycles must be at least 1");
    end

    logic [0:0]          state_q,     state_d;
    logic                tag_valid_q, tag_valid_d;
    logic [wordsize-1:0] tag_addr_q,  tag_addr_d;
    logic [wordsize-1:0] tag_wdata_q, tag_wdata_d;
    logic                tag_we_q,    tag_we_d;
    logic [wordsize-1:0] bus_addr_q,  bus_addr_d;
    logic [wordsize-1:0] bus_wdata_q, bus_wdata_d;
    logic                bus_we_q,    bus_we_d;
    logic [wordsize-1:0] data_in_q,   data_in_d;
    logic                load_tag;
    logic                match;

`ifdef REFLET_BUS_TIMEOUT_EN
    localparam int CNT_W = $clog2(timeout_cycles + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(timeout_cycles - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             error_q, error_d;

    assign bus.bus_error = error_q;
`else
    assign bus.bus_error = 1'b0;
`endif

    // A hit means the CPU is re-presenting the access that last completed;
    // write data only matters for writes.
    assign match = tag_valid_q
                && (cpu_addr == tag_addr_q)
                && (cpu_write_en == tag_we_q)
                && (!cpu_write_en || (cpu_data_out == tag_wdata_q));

    assign stall         = (state_q == ST_REQ) || ((state_q == ST_IDLE) && !match);
    assign cpu_data_in   = data_in_q;
    assign bus.bus_addr  = bus_addr_q;
    assign bus.bus_wdata = bus_wdata_q;
    assign bus.bus_we    = bus_we_q;
    assign bus.bus_req   = (state_q == ST_REQ);

    // Next-state logic: issue on a miss in IDLE, retire on ack (or timeout) in REQ
    always_comb begin
        // NOTE: every target gets a default up front so no path leaves a
        // variable unassigned, which would infer a latch.
        state_d     = state_q;
        tag_valid_d = tag_valid_q;
        tag_addr_d  = tag_addr_q;
        tag_wdata_d = tag_wdata_q;
        tag_we_d    = tag_we_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        bus_we_d    = bus_we_q;
        data_in_d   = data_in_q;
        load_tag    = 1'b0;
`ifdef REFLET_BUS_TIMEOUT_EN
        cnt_d       = cnt_q;
        error_d     = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (!match) begin
                    bus_addr_d  = cpu_addr;
                    bus_wdata_d = cpu_data_out;
                    bus_we_d    = cpu_write_en;
                    state_d     = ST_REQ;
`ifdef REFLET_BUS_TIMEOUT_EN
                    cnt_d       = '0;
`endif
                end
            end
            ST_REQ: begin
                if (bus.bus_ack) begin
                    if (!bus_we_q) begin
                        data_in_d = bus.bus_rdata;
                    end
                    load_tag = 1'b1;
                    state_d  = ST_IDLE;
                end
`ifdef REFLET_BUS_TIMEOUT_EN
                else if (cnt_q == CNT_LAST) begin
                    if (!bus_we_q) begin
                        data_in_d = '1;
                    end
                    load_tag = 1'b1;
                    error_d  = 1'b1;
                    state_d  = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
`endif
            end
            default: state_d = ST_IDLE;
        endcase

        if (load_tag) begin
            tag_valid_d = 1'b1;
            tag_addr_d  = bus_addr_q;
            tag_wdata_d = bus_wdata_q;
            tag_we_d    = bus_we_q;
        end
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values of the others.
        if (!reset) begin
            state_q     <= ST_IDLE;
            tag_valid_q <= 1'b0;
            tag_addr_q  <= '0;
            tag_wdata_q <= '0;
            tag_we_q    <= 1'b0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
            bus_we_q    <= 1'b0;
            data_in_q   <= '0;
`ifdef REFLET_BUS_TIMEOUT_EN
            cnt_q       <= '0;
            error_q     <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            tag_valid_q <= tag_valid_d;
            tag_addr_q  <= tag_addr_d;
            tag_wdata_q <= tag_wdata_d;
            tag_we_q    <= tag_we_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            bus_we_q    <= bus_we_d;
            data_in_q   <= data_in_d;
`ifdef REFLET_BUS_TIMEOUT_EN
            cnt_q       <= cnt_d;
            error_q     <= error_d;
`endif
        end
    end
endmodule

// File: doc/reflet_bus_bridge.md
REFLET_BUS_BRIDGE -- requirements
Module: reflet_bus_bridge

Interface
REQ-001 Parameter wordsize, default 16: width of address and data; legal values 8, 16, 32, 64.
REQ-002 Parameter timeout_cycles, default 255: maximum wait for bus_ack before abort; used only with REFLET_BUS_TIMEOUT_EN.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 reset  input  1  synchronous reset, active-low.
REQ-005 cpu_addr  input  wordsize  address from the CPU address unit.
REQ-006 cpu_data_out  input  wordsize  write data from the CPU.
REQ-007 cpu_write_en  input  1  CPU write strobe.
REQ-008 cpu_data_in  output  wordsize  read data returned to the CPU.
REQ-009 stall  output  1  freezes the CPU; the CPU enable is driven by !stall.
REQ-010 bus_addr, bus_wdata  output  wordsize each  registered request address and write data.
REQ-011 bus_we  output  1  registered request direction; 1 means write.
REQ-012 bus_req  output  1  request valid.
REQ-013 bus_ack  input  1  one-cycle completion strobe from memory.
REQ-014 bus_rdata  input  wordsize  read data, valid while bus_ack=1.
REQ-015 bus_error  output  1  one-cycle pulse when a transaction is aborted.

Function
REQ-016 FSM states: IDLE and REQ; reset state is IDLE.
REQ-017 Tag register: valid, addr, we, wdata; match = valid & cpu_addr==tag.addr & cpu_write_en==tag.we & (!cpu_write_en | cpu_data_out==tag.wdata).
REQ-018 stall = (state==REQ) | (state==IDLE & !match); this logic is combinational from the inputs.
REQ-019 IDLE & !match: on the edge, capture cpu_addr/cpu_data_out/cpu_write_en into bus_addr/bus_wdata/bus_we and enter REQ.
REQ-020 In REQ, bus_req=1. bus_addr, bus_wdata and bus_we stay stable until the ack edge.
REQ-021 REQ & bus_ack, on the edge:
- for a read, load bus_rdata into cpu_data_in
- load the tag from the bus_* registers and set valid=1
- return to IDLE
REQ-022 A write completion leaves cpu_data_in unchanged. The tag then holds we=1, so a subsequent read to the same address misses and is reissued.
REQ-023 Latency: a miss with bus_ack in the first REQ cycle gives stall high for exactly 2 cycles; each additional ack wait cycle adds 1.
REQ-024 bus_req is low for at least 1 cycle between consecutive transactions.
REQ-025 An input change while in REQ is ignored; the outstanding transaction completes, then the new value is compared in IDLE.
REQ-026 bus_ack while in IDLE is ignored.
REQ-027 A held identical write (same addr and data, we=1) after completion is a match and is not reissued.

Reset
REQ-028 While reset=0 at an edge:
- state=IDLE, valid=0
- bus_req=0, bus_we=0, bus_error=0
- bus_addr, bus_wdata and cpu_data_in cleared to 0
REQ-029 Reset during REQ drops bus_req on that same edge. A bus_ack arriving in the reset cycle is discarded.
REQ-030 In the first cycle after reset release, stall=1 because valid=0.

Configuration
REQ-031 Macro REFLET_BUS_TIMEOUT_EN.
REQ-032 With REFLET_BUS_TIMEOUT_EN defined:
- a counter runs during REQ
- if timeout_cycles REQ cycles pass without bus_ack: load all-ones into cpu_data_in (reads only), set the tag valid, pulse bus_error for 1 cycle, and enter IDLE
- the counter clears on entering REQ
REQ-033 Without REFLET_BUS_TIMEOUT_EN: REQ waits indefinitely, bus_error is tied to 0, and no counter logic exists.

Verification
REQ-034 Read with ack at first opportunity: cpu_addr=0x0010, bus_rdata=0xBEEF with bus_ack in the first REQ cycle -> stall=1 for 2 cycles, cpu_data_in=0xBEEF, bus_req asserted for 1 cycle.
REQ-035 Write then read-back: write 0x1234 to 0x0020, then read 0x0020 -> two separate transactions (bus_we=1 then bus_we=0), with bus_req low at least 1 cycle between them.
REQ-036 Slow memory: ack delayed 5 cycles -> stall=1 for 7 cycles, with bus_addr and bus_wdata constant throughout.
REQ-037 Reset mid-transaction: reset=0 during REQ with bus_ack=1 in the same cycle -> next cycle bus_req=0 and cpu_data_in=0; after release, stall=1.
REQ-038 Timeout (macro defined, timeout_cycles=4): no ack -> after 4 REQ cycles, bus_error pulses for 1 cycle, cpu_data_in=0xFFFF, then IDLE; without the macro, stall stays high indefinitely.
REQ-039 Repeated access: cpu_addr held at 0x0030 after a completed read -> no further bus_req and stall=0.
